// File: rtl/raw_from_32_pkg.sv
// Shared dtype codes, FSM state encoding and group geometry for the RAW
// 32-bit word to 16-bit pixel/halfword converter.
package raw_from_32_pkg;

  localparam int DTYPE_WIDTH = 4;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 4'h3;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 4'h4;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 4'h5;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 4'h8;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 4'h8;

  // Four MSB words plus one LSB word make a packed 16-pixel group.
  localparam int GROUP_WORDS = 5;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_HIGH,
    ST_EMIT,
    ST_ROW_END
  } state_t;

  function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dtype);
    return (dtype & DTYPE_PIXEL_MASK) != '0;
  endfunction

endpackage

// File: rtl/raw_unpack_group.sv
// Packed-group buffer: stores up to five 32-bit words, tracks the fill
// count and the emission index, and forms the 10-bit pixel for that index.
module raw_unpack_group
  import raw_from_32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        store,
  input  logic        start_full,
  input  logic        start_row,
  input  logic        advance,
  input  logic        clear,
  input  logic [31:0] data,
  output logic [2:0]  wcnt,
  output logic [15:0] pixel,
  output logic        last
);

  logic [31:0] grp_q [GROUP_WORDS];
  logic [3:0]  idx_q;
  logic [2:0]  k_q;

  logic        starting;
  logic [3:0]  sel_idx;
  logic [2:0]  sel_k;
  logic [31:0] msb_word;
  logic [31:0] lsb_word;
  logic [4:0]  lsb_off;
  logic [4:0]  bit_pos;
  logic [3:0]  npix_m1;

  // k is the slot holding the LSB word: 4 for a full group, wcnt-1 for a
  // row-end flush. The first pixel is formed in the same cycle the group is
  // started, so the fifth word is taken straight from the input.
  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    starting = start_full || start_row;
    sel_idx  = starting ? 4'd0 : idx_q;
    sel_k    = start_full ? 3'd4 : (start_row ? wcnt - 3'd1 : k_q);
    msb_word = grp_q[{1'b0, sel_idx[3:2]}];
    lsb_word = start_full ? data : grp_q[sel_k];
    // 32 - 8k modulo 32: a full group (k=4) starts its LSBs at bit 0.
    lsb_off  = 5'd0 - {sel_k[1:0], 3'b000};
    bit_pos  = lsb_off + {sel_idx, 1'b0};
    pixel    = {6'd0, msb_word[{sel_idx[1:0], 3'b000} +: 8], lsb_word[bit_pos +: 2]};
    npix_m1  = {sel_k[1:0], 2'b00} - 4'd1;
    last     = (sel_idx == npix_m1);
  end

  // NOTE: the group buffer is reset explicitly so no stale pixels survive a reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < GROUP_WORDS; i++) grp_q[i] <= '0;
      wcnt  <= '0;
      idx_q <= '0;
      k_q   <= '0;
    end else begin
      if (store) grp_q[wcnt] <= data;
      if (starting) begin
        wcnt  <= '0;
        idx_q <= 4'd1;
        k_q   <= sel_k;
      end else begin
        if (clear)      wcnt <= '0;
        else if (store) wcnt <= wcnt + 3'd1;
        if (advance)    idx_q <= idx_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/raw_from_32.sv
// RAW word-stream converter: splits 32-bit words into halfwords, or decodes
// 10-bit packed groups into one pixel per cycle, with dtype passthrough.
module raw_from_32
  import raw_from_32_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            datai,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic                   pack,
  output logic                   rdyo,
  output logic [15:0]            datao,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic                   overrun
);

  localparam logic PACK_OK = (PIXEL_WIDTH == 10);

  state_t                 state;
  logic                   pack_q;
  logic [15:0]            hi_q;
  logic [DTYPE_WIDTH-1:0] hi_type;
  logic                   row_end_q;

  logic        accept;
  logic        packed_mode;
  logic        word_split;
  logic        word_group;
  logic        grp_full;
  logic        row_flush;
  logic        grp_clear;
  logic [2:0]  wcnt;
  logic [15:0] pixel;
  logic        last;

  // rdyo is only high in ST_COLLECT, so every accepted word is decoded there.
  always_comb begin
    accept      = dvi && rdyo;
    packed_mode = pack_q && PACK_OK;
    word_split  = accept && (dtypei == DTYPE_HEADER || (is_pixel(dtypei) && !packed_mode));
    word_group  = accept && is_pixel(dtypei) && packed_mode;
    grp_full    = word_group && (wcnt == 3'd4);
    row_flush   = accept && (dtypei == DTYPE_ROW_END) && packed_mode && (wcnt >= 3'd2);
    grp_clear   = accept && !is_pixel(dtypei) && (dtypei != DTYPE_HEADER) && !row_flush;
  end

  raw_unpack_group u_group (
    .clk        (clk),
    .reset      (reset),
    .store      (word_group),
    .start_full (grp_full),
    .start_row  (row_flush),
    .advance    (state == ST_EMIT),
    .clear      (grp_clear),
    .data       (datai),
    .wcnt       (wcnt),
    .pixel      (pixel),
    .last       (last)
  );

  // NOTE: all registered outputs use non-blocking assignments; dvo defaults low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_COLLECT;
      rdyo      <= 1'b1;
      datao     <= '0;
      dvo       <= 1'b0;
      dtypeo    <= '0;
      overrun   <= 1'b0;
      pack_q    <= 1'b0;
      hi_q      <= '0;
      hi_type   <= '0;
      row_end_q <= 1'b0;
    end else begin
      dvo <= 1'b0;
      if (dvi && !rdyo) overrun <= 1'b1;

      case (state)
        ST_COLLECT: begin
          if (accept) begin
            if (dtypei == DTYPE_FRAME_START) pack_q <= pack;
            if (word_split) begin
              datao   <= datai[15:0];
              dtypeo  <= dtypei;
              dvo     <= 1'b1;
              hi_q    <= datai[31:16];
              hi_type <= dtypei;
              rdyo    <= 1'b0;
              state   <= ST_HIGH;
            end else if (grp_full || row_flush) begin
              datao     <= pixel;
              dtypeo    <= DTYPE_PIXEL;
              dvo       <= 1'b1;
              rdyo      <= 1'b0;
              row_end_q <= row_flush;
              state     <= ST_EMIT;
            end else if (!word_group) begin
              datao  <= '0;
              dtypeo <= dtypei;
              dvo    <= 1'b1;
            end
          end
        end

        ST_HIGH: begin
          datao  <= hi_q;
          dtypeo <= hi_type;
          dvo    <= 1'b1;
          rdyo   <= 1'b1;
          state  <= ST_COLLECT;
        end

        ST_EMIT: begin
          datao  <= pixel;
          dtypeo <= DTYPE_PIXEL;
          dvo    <= 1'b1;
          if (last) begin
            // A pending ROW_END still needs its own output slot, so hold off input.
            if (row_end_q) begin
              state <= ST_ROW_END;
            end else begin
              rdyo  <= 1'b1;
              state <= ST_COLLECT;
            end
          end
        end

        ST_ROW_END: begin
          datao     <= '0;
          dtypeo    <= DTYPE_ROW_END;
          dvo       <= 1'b1;
          rdyo      <= 1'b1;
          row_end_q <= 1'b0;
          state     <= ST_COLLECT;
        end

        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_raw_from_32.sv
// Self-checking bench for raw_from_32: directed cases plus random streams
// compared against a queue-based stream model of the word format.
module tb_raw_from_32;
  import raw_from_32_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] datai = '0;
  logic        dvi = 1'b0;
  logic [3:0]  dtypei = '0;
  logic        pack = 1'b0;
  logic        rdyo;
  logic [15:0] datao;
  logic        dvo;
  logic [3:0]  dtypeo;
  logic        overrun;

  always #5 clk = ~clk;

  raw_from_32 #(.PIXEL_WIDTH(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .datai   (datai),
    .dvi     (dvi),
    .dtypei  (dtypei),
    .pack    (pack),
    .rdyo    (rdyo),
    .datao   (datao),
    .dvo     (dvo),
    .dtypeo  (dtypeo),
    .overrun (overrun)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [19:0] ev;
    int          cyc;
  } ev_t;

  ev_t         got[$];
  logic [19:0] exp_q[$];
  logic        pack_m = 1'b0;
  logic [31:0] grp_m[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (dvo) got.push_back('{ev: {dtypeo, datao}, cyc: cyc});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Pixel i: MSB byte i%4 of word i/4, two LSBs from the LSB word at off+2i.
  task automatic emit_pix(input int n, input logic [31:0] lsb, input int off);
    logic [7:0] b;
    logic [1:0] l;
    for (int i = 0; i < n; i++) begin
      b = 8'(grp_m[i / 4] >> (8 * (i % 4)));
      l = 2'(lsb >> (off + 2 * i));
      exp_q.push_back({DTYPE_PIXEL, 6'd0, b, l});
    end
  endtask

  task automatic model_word(input logic [3:0] dt, input logic [31:0] d, input logic pk);
    int k;
    if (dt == DTYPE_FRAME_START) begin
      pack_m = pk;
      grp_m.delete();
      exp_q.push_back({dt, 16'h0});
    end else if (dt == DTYPE_HEADER || (dt == DTYPE_PIXEL && !pack_m)) begin
      exp_q.push_back({dt, d[15:0]});
      exp_q.push_back({dt, d[31:16]});
    end else if (dt == DTYPE_PIXEL) begin
      grp_m.push_back(d);
      if (grp_m.size() == 5) begin
        emit_pix(16, grp_m[4], 0);
        grp_m.delete();
      end
    end else if (dt == DTYPE_ROW_END && pack_m && grp_m.size() >= 2) begin
      k = grp_m.size() - 1;
      emit_pix(4 * k, grp_m[k], 32 - 8 * k);
      exp_q.push_back({dt, 16'h0});
      grp_m.delete();
    end else begin
      grp_m.delete();
      exp_q.push_back({dt, 16'h0});
    end
  endtask

  // Waits (bounded) for rdyo, presents the word for one accepted cycle and
  // returns on the negedge of the first output cycle.
  task automatic send(input logic [3:0] dt, input logic [31:0] d, input logic pk);
    int n = 0;
    while (rdyo !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("rdyo_wait", 32'(n < 64), 32'd1);
    dtypei = dt;
    datai  = d;
    pack   = pk;
    dvi    = 1'b1;
    model_word(dt, d, pk);
    @(negedge clk);
    dvi = 1'b0;
  endtask

  task automatic drain_compare(input string tag);
    repeat (40) @(negedge clk);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_ev%0d", tag, i), 32'(got[i].ev), 32'(exp_q[i]));
  endtask

  task automatic flush();
    got.delete();
    exp_q.delete();
  endtask

  task automatic send_group(input logic pk);
    for (int i = 0; i < 5; i++) send(DTYPE_PIXEL, $urandom, pk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  dt;
    logic [31:0] w;
    logic        pk;
    int          r;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_dvo", dvo, 0);
    check("rst_datao", datao, 0);
    check("rst_dtypeo", dtypeo, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rdyo", rdyo, 1);

    // Unpacked halfword split
    send(DTYPE_FRAME_START, 32'h0, 1'b0);
    send(DTYPE_PIXEL, 32'h0123_4567, 1'b0);
    check("u_lo_dvo", dvo, 1);
    check("u_lo_data", datao, 16'h4567);
    check("u_lo_rdyo", rdyo, 0);
    @(negedge clk);
    check("u_hi_data", datao, 16'h0123);
    check("u_hi_type", dtypeo, DTYPE_PIXEL);
    check("u_hi_rdyo", rdyo, 1);
    drain_compare("unpacked");
    flush();

    // Packed full group with known pixels {n, n%4}
    send(DTYPE_FRAME_START, 32'h0, 1'b1);
    send(DTYPE_PIXEL, 32'h0302_0100, 1'b1);
    send(DTYPE_PIXEL, 32'h0706_0504, 1'b1);
    send(DTYPE_PIXEL, 32'h0B0A_0908, 1'b1);
    send(DTYPE_PIXEL, 32'h0F0E_0D0C, 1'b1);
    send(DTYPE_PIXEL, 32'hE4E4_E4E4, 1'b1);
    check("full_p0", datao, 16'h000);
    check("full_p0_rdyo", rdyo, 0);
    repeat (14) @(negedge clk);
    check("full_p14", datao, 16'h03A);
    check("full_p14_rdyo", rdyo, 0);
    @(negedge clk);
    check("full_p15", datao, 16'h03F);
    check("full_p15_rdyo", rdyo, 1);
    drain_compare("full");
    flush();

    // Partial row: two MSB words, LSBs in 31:16, then ROW_END
    send(DTYPE_PIXEL, $urandom, 1'b1);
    send(DTYPE_PIXEL, $urandom, 1'b1);
    send(DTYPE_PIXEL, $urandom, 1'b1);
    send(DTYPE_ROW_END, 32'h0, 1'b1);
    drain_compare("partial");
    if (got.size() >= 2)
      check("partial_rowend_gap", 32'(got[got.size()-1].cyc - got[got.size()-2].cyc), 32'd1);
    flush();

    // Three words then FRAME_END: group discarded, next group still aligned
    for (int i = 0; i < 3; i++) send(DTYPE_PIXEL, $urandom, 1'b1);
    send(DTYPE_FRAME_END, $urandom, 1'b1);
    send_group(1'b1);
    drain_compare("discard");
    flush();

    // Overrun: word offered during EMIT is dropped
    send_group(1'b1);
    dtypei = DTYPE_HEADER;
    datai  = $urandom;
    dvi    = 1'b1;
    @(negedge clk);
    dvi = 1'b0;
    check("ovr_set", overrun, 1);
    drain_compare("overrun");
    check("ovr_sticky", overrun, 1);
    flush();

    // Reset at pixel 7 of a 12-pixel row flush: no ROW_END afterwards
    for (int i = 0; i < 4; i++) send(DTYPE_PIXEL, $urandom, 1'b1);
    send(DTYPE_ROW_END, 32'h0, 1'b1);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst7_dvo", dvo, 0);
    check("rst7_rdyo", rdyo, 1);
    check("rst7_overrun", overrun, 0);
    repeat (30) @(negedge clk);
    check("rst7_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < got.size()) check($sformatf("rst7_ev%0d", i), 32'(got[i].ev), 32'(exp_q[i]));
    flush();
    pack_m = 1'b0;
    grp_m.delete();
    send(DTYPE_FRAME_START, 32'h0, 1'b1);
    send_group(1'b1);
    drain_compare("after_rst");
    flush();

    // Random mixed streams
    for (int s = 0; s < 6; s++) begin
      send(DTYPE_FRAME_START, 32'h0, 1'($urandom_range(0, 1)));
      for (int n = 0; n < 40; n++) begin
        r  = $urandom_range(0, 15);
        w  = $urandom;
        pk = 1'($urandom_range(0, 1));
        if (r < 10)       dt = DTYPE_PIXEL;
        else if (r < 12)  dt = DTYPE_ROW_END;
        else if (r == 12) dt = DTYPE_HEADER;
        else if (r == 13) dt = DTYPE_ROW_START;
        else if (r == 14) dt = DTYPE_FRAME_END;
        else              dt = DTYPE_FRAME_START;
        send(dt, w, pk);
      end
      drain_compare($sformatf("rand%0d", s));
      flush();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
